// File: rtl/snitch_htif_pkg.sv
// Shared types and helpers for the HTIF tohost/fromhost mailbox.
// The state enum, the default register addresses and the byte-strobe merge live here.
package snitch_htif_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPending = 2'd1,
        StExited  = 2'd2
    } htif_state_e;

    localparam int unsigned HtifDataWidth = 64;
    localparam int unsigned HtifStrbWidth = HtifDataWidth / 8;

    localparam logic [47:0] DefaultTohostAddr   = 48'h0000_0000_1000;
    localparam logic [47:0] DefaultFromhostAddr = 48'h0000_0000_1008;

    // Replace every byte of old_val whose strobe bit is set with the matching byte of new_val.
    function automatic logic [HtifDataWidth-1:0] strb_merge(
        input logic [HtifDataWidth-1:0] old_val,
        input logic [HtifDataWidth-1:0] new_val,
        input logic [HtifStrbWidth-1:0] strb
    );
        logic [HtifDataWidth-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(HtifStrbWidth); i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/snitch_htif_rsp_reg.sv
// One-deep valid/ready response register carrying read data and an error flag.
// A new entry may be loaded in the same cycle the current one is consumed.
module snitch_htif_rsp_reg #(
    parameter int unsigned DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DataWidth-1:0] in_data_i,
    input  logic                 in_error_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 out_error_o
);

    logic                 valid_q;
    logic [DataWidth-1:0] data_q;
    logic                 error_q;

    assign in_ready_o = !valid_q || out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
            error_q <= in_error_i;
        end else if (out_ready_i) begin
            // Clear payload on hand-off so idle outputs read as zero.
            valid_q <= 1'b0;
            data_q  <= '0;
            error_q <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_error_o = error_q;

endmodule

// File: rtl/snitch_htif_mailbox.sv
// Device side of the HTIF mailbox: tohost/fromhost registers behind a single-outstanding
// request/response port, with a host poll/ack interface and a sticky exit-code latch.
module snitch_htif_mailbox
    import snitch_htif_pkg::*;
#(
    parameter int unsigned          AddrWidth    = 48,
    parameter int unsigned          DataWidth    = 64,
    parameter logic [AddrWidth-1:0] TohostAddr   = DefaultTohostAddr,
    parameter logic [AddrWidth-1:0] FromhostAddr = DefaultFromhostAddr
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_write_i,
    input  logic [DataWidth-1:0] req_data_i,
    input  logic [7:0]           req_strb_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_data_o,
    output logic                 rsp_error_o,
    output logic                 host_tohost_valid_o,
    output logic [DataWidth-1:0] host_tohost_o,
    input  logic                 host_ack_i,
    input  logic                 host_fromhost_valid_i,
    input  logic [DataWidth-1:0] host_fromhost_i,
    output logic                 exit_o,
    output logic [31:0]          exit_code_o
);

    htif_state_e          state_q;
    logic [DataWidth-1:0] tohost_q;
    logic [DataWidth-1:0] fromhost_q;
    logic                 exit_q;
    logic [31:0]          exit_code_q;

    logic                 is_tohost;
    logic                 is_fromhost;
    logic                 stall;
    logic                 rsp_in_ready;
    logic                 req_fire;
    logic                 tohost_wr;
    logic                 fromhost_wr;
    logic [DataWidth-1:0] tohost_merged;
    logic [DataWidth-1:0] fromhost_merged;
    logic [DataWidth-1:0] rd_data;
    logic                 unused_addr_lsb;

    // Registers are 8-byte aligned; the byte offset within a word is ignored.
    assign is_tohost       = req_addr_i[AddrWidth-1:3] == TohostAddr[AddrWidth-1:3];
    assign is_fromhost     = req_addr_i[AddrWidth-1:3] == FromhostAddr[AddrWidth-1:3];
    assign unused_addr_lsb = ^req_addr_i[2:0];

    // Only a new syscall must wait for the host; everything else keeps flowing.
    assign stall       = req_write_i && is_tohost && (state_q == StPending);
    assign req_ready_o = rsp_in_ready && !stall;
    assign req_fire    = req_valid_i && req_ready_o;

    assign tohost_wr   = req_fire && req_write_i && is_tohost;
    assign fromhost_wr = req_fire && req_write_i && is_fromhost;

    assign tohost_merged   = strb_merge(tohost_q, req_data_i, req_strb_i);
    assign fromhost_merged = strb_merge(fromhost_q, req_data_i, req_strb_i);

    always_comb begin
        rd_data = '0;
        if (!req_write_i) begin
            if (is_tohost) begin
                rd_data = tohost_q;
            end else if (is_fromhost) begin
                rd_data = fromhost_q;
            end
        end
    end

    snitch_htif_rsp_reg #(
        .DataWidth (DataWidth)
    ) u_rsp_reg (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (req_fire),
        .in_ready_o  (rsp_in_ready),
        .in_data_i   (rd_data),
        .in_error_i  (!(is_tohost || is_fromhost)),
        .out_valid_o (rsp_valid_o),
        .out_ready_i (rsp_ready_i),
        .out_data_o  (rsp_data_o),
        .out_error_o (rsp_error_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            tohost_q    <= '0;
            fromhost_q  <= '0;
            exit_q      <= 1'b0;
            exit_code_q <= '0;
        end else begin
            // Host write wins over a same-cycle core write; the core still gets a response.
            if (host_fromhost_valid_i) begin
                fromhost_q <= host_fromhost_i;
            end else if (fromhost_wr) begin
                fromhost_q <= fromhost_merged;
            end

            unique case (state_q)
                StIdle: begin
                    if (tohost_wr) begin
                        tohost_q <= tohost_merged;
                        // The action byte only fires when byte 0 was written.
                        if (req_strb_i[0]) begin
                            if (tohost_merged[0]) begin
                                state_q     <= StExited;
                                exit_q      <= 1'b1;
                                exit_code_q <= tohost_merged[32:1];
                            end else if (tohost_merged != '0) begin
                                state_q <= StPending;
                            end
                        end
                    end
                end
                StPending: begin
                    if (host_ack_i) begin
                        tohost_q <= '0;
                        state_q  <= StIdle;
                    end
                end
                StExited: begin
                    // Terminal: tohost writes are accepted and dropped.
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign host_tohost_valid_o = (state_q == StPending);
    assign host_tohost_o       = tohost_q;
    assign exit_o              = exit_q;
    assign exit_code_o         = exit_code_q;

endmodule

// File: tb/tb_snitch_htif_mailbox.sv
// Directed self-checking bench for snitch_htif_mailbox.
module tb_snitch_htif_mailbox;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready_o;
    logic [47:0] req_addr;
    logic        req_write;
    logic [63:0] req_data;
    logic [7:0]  req_strb;
    logic        rsp_valid_o;
    logic        rsp_ready;
    logic [63:0] rsp_data_o;
    logic        rsp_error_o;
    logic        host_tohost_valid_o;
    logic [63:0] host_tohost_o;
    logic        host_ack;
    logic        host_fh_valid;
    logic [63:0] host_fh;
    logic        exit_o;
    logic [31:0] exit_code_o;

    int tests_run;
    int tests_failed;

    snitch_htif_mailbox dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .req_valid_i           (req_valid),
        .req_ready_o           (req_ready_o),
        .req_addr_i            (req_addr),
        .req_write_i           (req_write),
        .req_data_i            (req_data),
        .req_strb_i            (req_strb),
        .rsp_valid_o           (rsp_valid_o),
        .rsp_ready_i           (rsp_ready),
        .rsp_data_o            (rsp_data_o),
        .rsp_error_o           (rsp_error_o),
        .host_tohost_valid_o   (host_tohost_valid_o),
        .host_tohost_o         (host_tohost_o),
        .host_ack_i            (host_ack),
        .host_fromhost_valid_i (host_fh_valid),
        .host_fromhost_i       (host_fh),
        .exit_o                (exit_o),
        .exit_code_o           (exit_code_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Leaves the bench 1 time unit after a rising edge, reset released.
    task automatic do_reset();
        req_valid     = 1'b0;
        req_addr      = '0;
        req_write     = 1'b0;
        req_data      = '0;
        req_strb      = '0;
        rsp_ready     = 1'b1;
        host_ack      = 1'b0;
        host_fh_valid = 1'b0;
        host_fh       = '0;
        rst_n         = 1'b0;
        #2;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Issues one request and returns 1 time unit after the accepting edge.
    task automatic core_req(input logic wr, input logic [47:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, output bit acc);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_data  = data;
        req_strb  = strb;
        acc       = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            #0;
            if (req_ready_o) acc = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        req_write = 1'b0;
        req_strb  = '0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (req_ready_o !== 1'b1) begin
            tests_failed++; $display("FAIL reset_req_ready: got %0h expected 1", req_ready_o);
        end
        tests_run++;
        if (rsp_valid_o !== 1'b0 || rsp_error_o !== 1'b0 || rsp_data_o !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_rsp: got v=%0h e=%0h d=%0h expected 0 0 0",
                     rsp_valid_o, rsp_error_o, rsp_data_o);
        end
        tests_run++;
        if (host_tohost_valid_o !== 1'b0 || host_tohost_o !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_host: got v=%0h t=%0h expected 0 0",
                     host_tohost_valid_o, host_tohost_o);
        end
        tests_run++;
        if (exit_o !== 1'b0 || exit_code_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_exit: got %0h/%0h expected 0/0", exit_o, exit_code_o);
        end
    endtask

    task automatic test_exit();
        bit acc;
        do_reset();
        core_req(1'b1, 48'h1000, 64'h1, 8'hFF, acc);
        tests_run++;
        if (acc !== 1'b1 || rsp_valid_o !== 1'b1 || rsp_error_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL exit1_rsp: got acc=%0h v=%0h e=%0h expected 1 1 0",
                     acc, rsp_valid_o, rsp_error_o);
        end
        tests_run++;
        if (exit_o !== 1'b1 || exit_code_o !== 32'd0 || host_tohost_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL exit1_flags: got exit=%0h code=%0h pend=%0h expected 1 0 0",
                     exit_o, exit_code_o, host_tohost_valid_o);
        end
        core_req(1'b1, 48'h1000, 64'h8000, 8'hFF, acc);
        tests_run++;
        if (acc !== 1'b1 || host_tohost_o !== 64'h1 || exit_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL exited_ignore: got acc=%0h tohost=%0h exit=%0h expected 1 1 1",
                     acc, host_tohost_o, exit_o);
        end
        do_reset();
        core_req(1'b1, 48'h1000, 64'h15, 8'hFF, acc);
        tests_run++;
        if (exit_o !== 1'b1 || exit_code_o !== 32'd10) begin
            tests_failed++;
            $display("FAIL exit15_code: got exit=%0h code=%0d expected 1 10", exit_o, exit_code_o);
        end
    endtask

    task automatic test_syscall();
        bit acc;
        do_reset();
        core_req(1'b1, 48'h1000, 64'h8000_1000, 8'hFF, acc);
        tests_run++;
        if (host_tohost_valid_o !== 1'b1 || host_tohost_o !== 64'h8000_1000 || exit_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL syscall_pending: got v=%0h t=%0h exit=%0h expected 1 80001000 0",
                     host_tohost_valid_o, host_tohost_o, exit_o);
        end
        host_fh_valid = 1'b1;
        host_fh       = 64'h1;
        @(posedge clk); #1;
        host_fh_valid = 1'b0;
        host_ack      = 1'b1;
        @(posedge clk); #1;
        host_ack = 1'b0;
        tests_run++;
        if (host_tohost_valid_o !== 1'b0 || host_tohost_o !== 64'h0) begin
            tests_failed++;
            $display("FAIL syscall_ack: got v=%0h t=%0h expected 0 0",
                     host_tohost_valid_o, host_tohost_o);
        end
        core_req(1'b0, 48'h1000, 64'h0, 8'h00, acc);
        tests_run++;
        if (rsp_data_o !== 64'h0 || rsp_error_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL syscall_rd_tohost: got %0h/%0h expected 0/0", rsp_data_o, rsp_error_o);
        end
        core_req(1'b0, 48'h1008, 64'h0, 8'h00, acc);
        tests_run++;
        if (rsp_data_o !== 64'h1 || rsp_valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL syscall_rd_fromhost: got %0h v=%0h expected 1 1", rsp_data_o, rsp_valid_o);
        end
    endtask

    task automatic test_stall();
        bit acc;
        do_reset();
        core_req(1'b1, 48'h1000, 64'h42, 8'hFF, acc);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 48'h1000;
        req_data  = 64'h44;
        req_strb  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (req_ready_o !== 1'b0) begin
                tests_failed++; $display("FAIL stall_ready_%0d: got %0h expected 0", i, req_ready_o);
            end
            @(posedge clk); #1;
        end
        host_ack = 1'b1;
        #1;
        tests_run++;
        if (req_ready_o !== 1'b0) begin
            tests_failed++; $display("FAIL stall_ack_cycle: got %0h expected 0", req_ready_o);
        end
        @(posedge clk); #1;
        host_ack = 1'b0;
        #1;
        tests_run++;
        if (req_ready_o !== 1'b1 || host_tohost_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_release: got rdy=%0h pend=%0h expected 1 0",
                     req_ready_o, host_tohost_valid_o);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'b0;
        tests_run++;
        if (rsp_valid_o !== 1'b1 || host_tohost_valid_o !== 1'b1 || host_tohost_o !== 64'h44) begin
            tests_failed++;
            $display("FAIL stall_accept: got v=%0h pend=%0h t=%0h expected 1 1 44",
                     rsp_valid_o, host_tohost_valid_o, host_tohost_o);
        end
    endtask

    task automatic test_strobes();
        bit acc;
        do_reset();
        host_fh_valid = 1'b1;
        host_fh       = 64'hAA;
        core_req(1'b1, 48'h1008, 64'h0, 8'hFF, acc);
        host_fh_valid = 1'b0;
        tests_run++;
        if (acc !== 1'b1 || rsp_valid_o !== 1'b1 || rsp_error_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL collide_rsp: got acc=%0h v=%0h e=%0h expected 1 1 0",
                     acc, rsp_valid_o, rsp_error_o);
        end
        core_req(1'b0, 48'h1008, 64'h0, 8'h00, acc);
        tests_run++;
        if (rsp_data_o !== 64'hAA) begin
            tests_failed++; $display("FAIL collide_fromhost: got %0h expected aa", rsp_data_o);
        end
        core_req(1'b1, 48'h1008, 64'h1122, 8'h01, acc);
        core_req(1'b0, 48'h1008, 64'h0, 8'h00, acc);
        tests_run++;
        if (rsp_data_o !== 64'h22) begin
            tests_failed++; $display("FAIL fromhost_merge: got %0h expected 22", rsp_data_o);
        end
        // Byte 0 not written: value merges but no action is taken.
        core_req(1'b1, 48'h1000, 64'h0300, 8'h02, acc);
        tests_run++;
        if (host_tohost_o !== 64'h300 || host_tohost_valid_o !== 1'b0 || exit_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL tohost_nostrb0: got t=%0h pend=%0h exit=%0h expected 300 0 0",
                     host_tohost_o, host_tohost_valid_o, exit_o);
        end
        core_req(1'b1, 48'h1000, 64'h02, 8'h01, acc);
        tests_run++;
        if (host_tohost_o !== 64'h302 || host_tohost_valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL tohost_strb0: got t=%0h pend=%0h expected 302 1",
                     host_tohost_o, host_tohost_valid_o);
        end
    endtask

    task automatic test_unmapped();
        bit acc;
        do_reset();
        rsp_ready = 1'b0;
        core_req(1'b0, 48'h2000, 64'h0, 8'h00, acc);
        tests_run++;
        if (rsp_valid_o !== 1'b1 || rsp_error_o !== 1'b1 || rsp_data_o !== 64'h0) begin
            tests_failed++;
            $display("FAIL unmapped_rd: got v=%0h e=%0h d=%0h expected 1 1 0",
                     rsp_valid_o, rsp_error_o, rsp_data_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (rsp_valid_o !== 1'b1 || rsp_error_o !== 1'b1 || req_ready_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL unmapped_hold_%0d: got v=%0h e=%0h rdy=%0h expected 1 1 0",
                         i, rsp_valid_o, rsp_error_o, req_ready_o);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (rsp_valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL unmapped_drain: got %0h expected 0", rsp_valid_o);
        end
        core_req(1'b1, 48'h2008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, acc);
        tests_run++;
        if (rsp_error_o !== 1'b1 || host_tohost_o !== 64'h0) begin
            tests_failed++;
            $display("FAIL unmapped_wr: got e=%0h t=%0h expected 1 0", rsp_error_o, host_tohost_o);
        end
        core_req(1'b0, 48'h1008, 64'h0, 8'h00, acc);
        tests_run++;
        if (rsp_data_o !== 64'h0) begin
            tests_failed++; $display("FAIL unmapped_wr_fromhost: got %0h expected 0", rsp_data_o);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        do_reset();
        core_req(1'b1, 48'h1000, 64'h0300, 8'h02, acc);
        host_fh_valid = 1'b1;
        host_fh       = 64'h55;
        @(posedge clk); #1;
        host_fh_valid = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 48'h100F;
        @(posedge clk); #1;
        req_addr = 48'h1004;
        tests_run++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== 64'h55 || req_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first: got v=%0h d=%0h rdy=%0h expected 1 55 1",
                     rsp_valid_o, rsp_data_o, req_ready_o);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        tests_run++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== 64'h300) begin
            tests_failed++;
            $display("FAIL b2b_second: got v=%0h d=%0h expected 1 300", rsp_valid_o, rsp_data_o);
        end
    endtask

    task automatic test_async_reset();
        bit acc;
        do_reset();
        core_req(1'b1, 48'h1000, 64'h80, 8'hFF, acc);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        core_req(1'b0, 48'h1008, 64'h0, 8'h00, acc);
        tests_run++;
        if (rsp_valid_o !== 1'b1 || host_tohost_valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_pre: got v=%0h pend=%0h expected 1 1",
                     rsp_valid_o, host_tohost_valid_o);
        end
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || rsp_data_o !== 64'h0) begin
            tests_failed++;
            $display("FAIL areset_rsp: got v=%0h rdy=%0h d=%0h expected 0 1 0",
                     rsp_valid_o, req_ready_o, rsp_data_o);
        end
        tests_run++;
        if (host_tohost_valid_o !== 1'b0 || host_tohost_o !== 64'h0 || exit_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_host: got pend=%0h t=%0h exit=%0h expected 0 0 0",
                     host_tohost_valid_o, host_tohost_o, exit_o);
        end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_exit();
        test_syscall();
        test_stall();
        test_strobes();
        test_unmapped();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/snitch_htif_mailbox.md
# snitch_htif_mailbox

Device-side end of the host/target (HTIF) mailbox used by `fesvr` simulation. It holds the `tohost`/`fromhost` register pair behind a single-outstanding request/response port driven by the cluster's peripheral crossbar. It exposes a poll/acknowledge interface that the host-side tick routine samples, and it latches the program exit code when software writes `tohost` with bit 0 set. It sits inside the test harness, next to the cluster, as the target the host polls.

## Interface
- `AddrWidth`, 48, request address width.
- `DataWidth`, 64, data width (fixed at 64; `tohost`/`fromhost` are 64-bit).
- `TohostAddr`, 48'h0000_0000_1000, byte address of `tohost` (8-byte aligned).
- `FromhostAddr`, 48'h0000_0000_1008, byte address of `fromhost` (8-byte aligned).
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: core request valid.
- `req_ready_o` out 1: request accepted when valid && ready.
- `req_addr_i` in AddrWidth: byte address; bits [2:0] ignored.
- `req_write_i` in 1: 1 = write, 0 = read.
- `req_data_i` in 64: write data.
- `req_strb_i` in 8: byte strobes.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response accepted.
- `rsp_data_o` out 64: read data (0 for writes).
- `rsp_error_o` out 1: address matched neither register.
- `host_tohost_valid_o` out 1: a syscall request is pending for the host.
- `host_tohost_o` out 64: current `tohost` value.
- `host_ack_i` in 1: host has consumed the pending `tohost`.
- `host_fromhost_valid_i` in 1: host writes `fromhost`.
- `host_fromhost_i` in 64: host write data.
- `exit_o` out 1: program finished (sticky).
- `exit_code_o` out 32: `tohost[32:1]` captured at exit.

## Operation
- State machine with three states:
  - IDLE: `tohost` is free.
  - PENDING: a syscall is waiting for the host.
  - EXITED: terminal until reset.
- Request handling:
  - At most one response is in flight. `req_ready_o = !rsp_valid_o || rsp_ready_i`, ANDed with the stall condition below.
  - An accepted request produces its response registered on the next cycle. The response holds stable until `rsp_ready_i`.
- Write to `TohostAddr`:
  - Bytes are merged per strobe into `tohost`.
  - The action is evaluated on the merged value only if `req_strb_i[0]` is set.
  - Merged value 0: stay IDLE.
  - Bit 0 = 1: go to EXITED. Set `exit_o` and latch `exit_code_o`.
  - Otherwise: go to PENDING.
- Stall: a `tohost` write while in PENDING is stalled (`req_ready_o` = 0) until the host acknowledges. Other requests are not stalled.
- `host_ack_i` in PENDING:
  - Clears `tohost` to 0 and returns to IDLE.
  - Ignored in IDLE and EXITED.
- `fromhost` writes:
  - A host write sets `fromhost` in the next cycle.
  - A core write merges bytes.
  - If both occur in the same cycle, the host write wins. The core still receives its response.
- Reads return the register value as of the accept cycle.
- Unmapped addresses: read 0, write ignored, `rsp_error_o` = 1.
- In EXITED: `tohost` writes are accepted and ignored. `fromhost` behaves as normal.
- `host_tohost_valid_o` = (state == PENDING). `host_tohost_o` is always `tohost`.

## Timing
- Reset values: all outputs 0 except `req_ready_o` = 1. `tohost` = `fromhost` = 0. State = IDLE.
- A mid-operation reset drops any in-flight response and pending syscall immediately (asynchronous).
- Accept at cycle N gives `rsp_valid_o` at N+1. Back-to-back throughput is 1/cycle when `rsp_ready_i` = 1.
- A `tohost` write accepted at N gives `host_tohost_valid_o` or `exit_o` at N+1.
- `host_ack_i` at N: `host_tohost_valid_o` = 0 at N+1. A stalled `tohost` write can be accepted at N+1.

## Structure
- Package `snitch_htif_pkg`:
  - State enum `htif_state_e`.
  - Default address localparams.
  - Function `strb_merge(old, new, strb)`.
- One sub-module is natural: `snitch_htif_rsp_reg`, a one-deep valid/ready response register carrying data and error.

## Test plan
- Write `tohost` = 0x1, full strobe -> `exit_o` = 1 and `exit_code_o` = 0 next cycle. Write 0x15 after reset -> `exit_code_o` = 10.
- Write `tohost` = 0x8000_1000 -> `host_tohost_valid_o` = 1 with `host_tohost_o` = 0x8000_1000. Host writes `fromhost` = 0x1, then pulses ack -> PENDING cleared, `tohost` reads 0, `fromhost` reads 0x1.
- Second `tohost` write while PENDING -> `req_ready_o` = 0 until the ack cycle + 1, then accepted.
- Same-cycle host `fromhost` = 0xAA and core write `fromhost` = 0x0 -> `fromhost` reads 0xAA, core gets its response.
- Read 0x2000 -> `rsp_data_o` = 0, `rsp_error_o` = 1. Hold `rsp_ready_i` = 0 for 3 cycles -> response stable and `req_ready_o` = 0.
- Assert `rst_ni` = 0 while PENDING with a response stalled -> all outputs return to reset values asynchronously.
